dmem_byte_ctrl: RTL
===================

Name: dmem_byte_ctrl

Overview:
- Data-memory controller directly downstream of the mem stage. Consumes its word-wide request (mem_ce/we/addr/sel/data) and returns the raw 32-bit word on the mem stage's mem_data_i input.
- Serialises each request into byte transactions on an 8-bit req/ack external data bus.
- Holds the pipeline through the ctrl stall request until the access completes.

Parameters:
- TIMEOUT, 255: maximum cycles a byte transaction waits for bus_ack_i before it is aborted.
- TO_W, 8: width of the timeout counter; TIMEOUT must be less than 2**TO_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_ce_i  in  1  request valid, from the mem stage.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_addr_i  in  32  byte address.
- mem_sel_i  in  4  store byte-lane enables; ignored for loads.
- mem_data_i  in  32  store data, lane k on bits [8k+7:8k].
- mem_data_o  out  32  assembled load word, to the mem stage.
- stallreq_o  out  1  stall request to ctrl.
- err_o  out  1  one-cycle pulse, in the DONE cycle, when any lane of the request timed out.
- bus_req_o  out  1  byte transaction request.
- bus_we_o  out  1  transaction is a write.
- bus_addr_o  out  32  byte address, {addr[31:2], lane[1:0]}.
- bus_wdata_o  out  8  write byte.
- bus_rdata_i  in  8  read byte, valid when bus_ack_i = 1.
- bus_ack_i  in  1  transaction complete; sampled only while bus_req_o = 1.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state IDLE.
  - mem_data_o = 0, bus_req_o = 0, bus_we_o = 0, bus_addr_o = 0, bus_wdata_o = 0, err_o = 0.
  - Lane counter, lane mask and timeout counter cleared.
  - Reset mid-transfer drops bus_req_o immediately and abandons the request.
- States: IDLE, BUSY, DONE.
- IDLE, mem_ce_i = 1:
  - Latch we, addr[31:2], sel and data.
  - Lane mask = 4'b1111 for a load, mem_sel_i for a store.
  - Mask nonzero: go to BUSY, start at the lowest set lane.
  - Mask zero (store with sel 0000): go to DONE, no bus activity.
- Latched copy: later changes on mem_*_i are ignored until return to IDLE.
- Precondition: ctrl freezes ex_mem while stallreq_o = 1, so the request fields stay stable. The bench checks this.
- BUSY:
  - bus_req_o = 1, with bus_addr_o, bus_we_o and bus_wdata_o (latched data byte of the current lane) held stable until ack.
  - On the ack edge, a read lane captures bus_rdata_i into mem_data_o bits [8k+7:8k].
  - Then advance to the next set lane in ascending order.
  - bus_req_o stays 1 across consecutive lanes; the address changes the cycle after ack.
  - After the last lane's ack: bus_req_o = 0 and go to DONE.
  - Minimum one cycle per lane. A 4-lane load with immediate ack takes 4 BUSY cycles plus 1 DONE cycle.
- Timeout:
  - The counter clears at each lane start and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT, the lane is aborted: read byte = 8'h00, sticky error flag set, advance as if acked.
  - An ack in the same cycle the counter reaches TIMEOUT takes priority; that lane is not an error.
- DONE: lasts exactly one cycle.
  - stallreq_o = 0 and mem_data_o is valid, so the pipeline advances at the end of this cycle.
  - err_o = sticky flag, which then clears. Next state is IDLE.
- stallreq_o is combinational: (state == IDLE && mem_ce_i) || state == BUSY.
  - The first stall cycle is the request cycle itself.
  - Back-to-back requests: DONE, then IDLE, where the new request is latched.
- Lanes not read keep their previous mem_data_o value; loads always fetch all 4 lanes.
- Address bits [1:0] of mem_addr_i are ignored; the mem stage does lane extraction.
- mem_data_o keeps its value after a store and in IDLE.

Test Plan:
- Load: addr 0x100, bytes at 0x100..0x103 = 11,22,33,44, immediate ack -> bus_addr_o 0x100..0x103 in order; mem_data_o = 0x44332211 in DONE; stallreq_o high 5 cycles (request cycle plus 4 BUSY).
- Store: sel 4'b0100, data 0xAABBCCDD, addr 0x202 -> exactly one write at bus_addr_o 0x202, bus_wdata_o 0xBB; stallreq_o high 2 cycles.
- Store with sel 0000 -> no bus_req_o; stallreq_o high 1 cycle; DONE next.
- Load with ack delayed 3 cycles per lane -> bus address and control stable while waiting; 16 BUSY cycles; correct word assembled.
- Store with sel 1111, no ack on lane 1, TIMEOUT = 4 -> lane 1 aborted after 4 cycles; remaining lanes written; err_o pulses once in DONE.
- Reset asserted mid-BUSY, then a back-to-back load followed by a store -> bus_req_o low immediately on reset; after release both requests complete in order, with DONE and IDLE cycles between them.

Source files
------------

// File: rtl/dmem_byte_ctrl.sv
// ============================================================================
// dmem_byte_ctrl : serialises word loads/stores into byte req/ack transactions
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_byte_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stallreq_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  input  logic [7:0]  bus_rdata_i,
  input  logic        bus_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [TO_W:0] TO_LIM = (TO_W + 1)'(TIMEOUT);

  state_t        state;
  logic          we_q;
  logic [29:0]   addr_q;
  logic [31:0]   data_q;
  logic [3:0]    mask;
  logic [1:0]    lane;
  logic [TO_W-1:0] to_cnt;
  logic          err_flag;

  logic [3:0]    req_mask;
  logic [1:0]    first_lane;
  logic [1:0]    next_lane;
  logic          has_next;
  logic [TO_W:0] cnt_next;
  logic          lane_to;
  logic          lane_end;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr_i[1:0];

  // Lane selection: lowest set lane of the incoming request, and the next set
  // lane above the current one within the latched mask.
  always_comb begin
    req_mask   = mem_we_i ? mem_sel_i : 4'b1111;
    first_lane = 2'd0;
    next_lane  = 2'd0;
    has_next   = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req_mask[k]) first_lane = 2'(k);
      if (mask[k] && (k > int'(lane))) begin
        next_lane = 2'(k);
        has_next  = 1'b1;
      end
    end
  end

  // Ack in the cycle the counter would reach TIMEOUT wins over the abort.
  assign cnt_next = {1'b0, to_cnt} + {{TO_W{1'b0}}, 1'b1};
  assign lane_to  = !bus_ack_i && (cnt_next == TO_LIM);
  assign lane_end = bus_ack_i || lane_to;

  assign stallreq_o = ((state == IDLE) && mem_ce_i) || (state == BUSY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      mask        <= '0;
      lane        <= '0;
      to_cnt      <= '0;
      err_flag    <= 1'b0;
      mem_data_o  <= '0;
      err_o       <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_ce_i) begin
            we_q     <= mem_we_i;
            addr_q   <= mem_addr_i[31:2];
            data_q   <= mem_data_i;
            mask     <= req_mask;
            lane     <= first_lane;
            to_cnt   <= '0;
            err_flag <= 1'b0;
            if (req_mask != 4'b0000) begin
              state       <= BUSY;
              bus_req_o   <= 1'b1;
              bus_we_o    <= mem_we_i;
              bus_addr_o  <= {mem_addr_i[31:2], first_lane};
              bus_wdata_o <= mem_data_i[{first_lane, 3'b000} +: 8];
            end else begin
              state <= DONE;
            end
          end
        end
        BUSY: begin
          if (lane_end) begin
            if (!we_q) mem_data_o[{lane, 3'b000} +: 8] <= bus_ack_i ? bus_rdata_i : 8'h00;
            if (has_next) begin
              lane        <= next_lane;
              to_cnt      <= '0;
              err_flag    <= err_flag | lane_to;
              bus_addr_o  <= {addr_q, next_lane};
              bus_wdata_o <= data_q[{next_lane, 3'b000} +: 8];
            end else begin
              state     <= DONE;
              bus_req_o <= 1'b0;
              err_o     <= err_flag | lane_to;
              err_flag  <= 1'b0;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DONE: begin
          err_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
